// File: rtl/ddr_sched_pkg.sv
// Shared types and constants for the DDR read/write scheduler.
// Provides the scheduler state encoding, the MIG command codes and a
// helper that sizes phrase pointers for a given circular region length.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    WAIT_CALIB = 3'd0,
    ARB        = 3'd1,
    ISSUE_WR   = 3'd2,
    ISSUE_RD   = 3'd3
  } sched_state_t;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;

  // Pointer width able to hold 0..max-1 (at least one bit).
  function automatic int ptr_width(input int max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Wrapping up-counter over 0..MAX-1.
// Ports:
//   clk_in    clock
//   rst_in    synchronous active-high reset (count -> 0)
//   clear_in  restart from 0; combined with incr_in the result is 0+1
//   incr_in   advance by one, wrapping MAX-1 -> 0
//   count_out current count
module wrap_counter #(
  parameter int MAX   = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             clear_in,
  input  logic             incr_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] base;

  always_comb begin
    base    = clear_in ? '0 : count_q;
    count_d = base;
    if (incr_in) begin
      count_d = (base == WIDTH'(MAX - 1)) ? '0 : base + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/ddr_rw_scheduler.sv
// Time-shares the MIG user interface between the sample-write phrase stream
// and the playback read stream over a circular phrase region.
// Optional build macro: DDR_RW_SCHEDULER_STATS_EN adds wr_count, rd_count
// and stall_count outputs (saturating 32-bit counters).
// Ports:
//   clk_in, rst_in              ui_clk and its synchronous active-high reset
//   init_calib_complete         MIG calibration done (checked once)
//   app_*                       MIG command / write-data / read-return interface
//   write_axis_*                write phrase FIFO (ready is a pop strobe)
//   read_axis_*                 playback FIFO feed, af = prog_full
//   state_out                   current scheduler state
//
// state      | meaning
// WAIT_CALIB | idle until MIG calibration completes
// ARB        | choose between a write and a read (or wait)
// ISSUE_WR   | hold write command and write data until each handshakes
// ISSUE_RD   | hold read command until accepted
module ddr_rw_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int MAX_ADDRESS     = 45000,
  parameter int MAX_OUTSTANDING = 8,
  parameter int ADDR_STRIDE     = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         init_calib_complete,
  output logic [26:0]  app_addr,
  output logic [2:0]   app_cmd,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [127:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_rdy,
  input  logic [127:0] app_rd_data,
  input  logic         app_rd_data_valid,
  output logic         app_sr_req,
  output logic         app_ref_req,
  output logic         app_zq_req,
  input  logic         write_axis_valid,
  output logic         write_axis_ready,
  input  logic [127:0] write_axis_data,
  input  logic         write_axis_tuser,
  input  logic         write_axis_smallpile,
  output logic         read_axis_valid,
  output logic [127:0] read_axis_data,
  output logic         read_axis_tuser,
  input  logic         read_axis_af,
  output logic [2:0]   state_out
`ifdef DDR_RW_SCHEDULER_STATS_EN
  ,
  output logic [31:0]  wr_count,
  output logic [31:0]  rd_count,
  output logic [31:0]  stall_count
`endif
);

  localparam int PW = ptr_width(MAX_ADDRESS);

  sched_state_t   state_q, state_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [PW-1:0]  addr_q, addr_d;
  logic           cmd_done_q, cmd_done_d;
  logic           data_done_q, data_done_d;
  logic           last_wr_q, last_wr_d;
  logic [3:0]     outstanding_q, outstanding_d;

  logic [PW-1:0]  wr_ptr, rd_ptr, ret_ptr;
  logic           wr_clear, wr_incr, rd_incr;
  logic           can_wr, can_rd;

  wrap_counter #(.MAX(MAX_ADDRESS), .WIDTH(PW)) u_wr_ptr (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(wr_clear), .incr_in(wr_incr), .count_out(wr_ptr)
  );
  wrap_counter #(.MAX(MAX_ADDRESS), .WIDTH(PW)) u_rd_ptr (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(1'b0), .incr_in(rd_incr), .count_out(rd_ptr)
  );
  wrap_counter #(.MAX(MAX_ADDRESS), .WIDTH(PW)) u_ret_ptr (
    .clk_in(clk_in), .rst_in(rst_in), .clear_in(1'b0), .incr_in(app_rd_data_valid), .count_out(ret_ptr)
  );

  always_comb begin
    state_d          = state_q;
    wdata_d          = wdata_q;
    addr_d           = addr_q;
    cmd_done_d       = cmd_done_q;
    data_done_d      = data_done_q;
    last_wr_d        = last_wr_q;
    app_en           = 1'b0;
    app_cmd          = MIG_CMD_WRITE;
    app_wdf_wren     = 1'b0;
    write_axis_ready = 1'b0;
    wr_clear         = 1'b0;
    wr_incr          = 1'b0;
    rd_incr          = 1'b0;
    can_wr           = write_axis_valid;
    can_rd           = !read_axis_af && (outstanding_q < 4'(MAX_OUTSTANDING));

    case (state_q)
      WAIT_CALIB: begin
        if (init_calib_complete) state_d = ARB;
      end
      ARB: begin
        // Write wins when the write FIFO is filling up, when no read is
        // possible, or when it is the write's turn in the alternation.
        if (can_wr && (!write_axis_smallpile || !can_rd || !last_wr_q)) begin
          write_axis_ready = 1'b1;
          wdata_d          = write_axis_data;
          addr_d           = write_axis_tuser ? '0 : wr_ptr;
          wr_clear         = write_axis_tuser;
          wr_incr          = 1'b1;
          last_wr_d        = 1'b1;
          cmd_done_d       = 1'b0;
          data_done_d      = 1'b0;
          state_d          = ISSUE_WR;
        end else if (can_rd) begin
          addr_d    = rd_ptr;
          last_wr_d = 1'b0;
          state_d   = ISSUE_RD;
        end
      end
      ISSUE_WR: begin
        // Command and data handshakes complete independently.
        app_en       = !cmd_done_q;
        app_wdf_wren = !data_done_q;
        cmd_done_d   = cmd_done_q || app_rdy;
        data_done_d  = data_done_q || app_wdf_rdy;
        if (cmd_done_d && data_done_d) state_d = ARB;
      end
      ISSUE_RD: begin
        app_en  = 1'b1;
        app_cmd = MIG_CMD_READ;
        if (app_rdy) begin
          rd_incr = 1'b1;
          state_d = ARB;
        end
      end
      default: state_d = WAIT_CALIB;
    endcase

    outstanding_d = outstanding_q;
    if (rd_incr && !app_rd_data_valid) outstanding_d = outstanding_q + 4'd1;
    else if (!rd_incr && app_rd_data_valid) outstanding_d = outstanding_q - 4'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= WAIT_CALIB;
      wdata_q       <= '0;
      addr_q        <= '0;
      cmd_done_q    <= 1'b0;
      data_done_q   <= 1'b0;
      last_wr_q     <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      wdata_q       <= wdata_d;
      addr_q        <= addr_d;
      cmd_done_q    <= cmd_done_d;
      data_done_q   <= data_done_d;
      last_wr_q     <= last_wr_d;
      outstanding_q <= outstanding_d;
    end
  end

  // A return with nothing outstanding, or a read beyond the limit, means
  // the MIG or the playback FIFO contract has been broken.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(app_rd_data_valid && !rd_incr && outstanding_q == 4'd0));
      assert (!(rd_incr && !app_rd_data_valid && outstanding_q >= 4'(MAX_OUTSTANDING)));
    end
  end

  assign app_addr        = 27'(addr_q) * 27'(ADDR_STRIDE);
  assign app_wdf_data    = wdata_q;
  assign app_wdf_end     = app_wdf_wren;
  assign app_wdf_mask    = '0;
  assign app_sr_req      = 1'b0;
  assign app_ref_req     = 1'b0;
  assign app_zq_req      = 1'b0;
  assign read_axis_valid = app_rd_data_valid;
  assign read_axis_data  = app_rd_data;
  assign read_axis_tuser = (ret_ptr == '0);
  assign state_out       = state_q;

`ifdef DDR_RW_SCHEDULER_STATS_EN
  logic [31:0] wr_count_q, wr_count_d;
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    wr_count_d    = wr_count_q;
    rd_count_d    = rd_count_q;
    stall_count_d = stall_count_q;
    if (state_q == ISSUE_WR && !cmd_done_q && app_rdy && wr_count_q != '1)
      wr_count_d = wr_count_q + 32'd1;
    if (rd_incr && rd_count_q != '1)
      rd_count_d = rd_count_q + 32'd1;
    if (app_en && !app_rdy && stall_count_q != '1)
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign wr_count    = wr_count_q;
  assign rd_count    = rd_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Directed bench for ddr_rw_scheduler with a small region (4 phrases) and a
// read limit of 2. Expected commands, write data and returned phrases are
// queued when stimulus is driven and popped by a monitor on the falling edge.
module tb_ddr_rw_scheduler;

  localparam int MAXA = 4;
  localparam int MAXO = 2;
  localparam int STRIDE = 8;
  localparam logic [2:0] CW = 3'b000;
  localparam logic [2:0] CR = 3'b001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, calib;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [15:0]  app_wdf_mask;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_sr_req, app_ref_req, app_zq_req;
  logic         write_axis_valid, write_axis_ready, write_axis_tuser, write_axis_smallpile;
  logic [127:0] write_axis_data;
  logic         read_axis_valid, read_axis_tuser, read_axis_af;
  logic [127:0] read_axis_data;
  logic [2:0]   state_out;

  ddr_rw_scheduler #(.MAX_ADDRESS(MAXA), .MAX_OUTSTANDING(MAXO), .ADDR_STRIDE(STRIDE)) dut (
    .clk_in(clk), .rst_in(rst), .init_calib_complete(calib),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
    .write_axis_valid(write_axis_valid), .write_axis_ready(write_axis_ready),
    .write_axis_data(write_axis_data), .write_axis_tuser(write_axis_tuser),
    .write_axis_smallpile(write_axis_smallpile),
    .read_axis_valid(read_axis_valid), .read_axis_data(read_axis_data),
    .read_axis_tuser(read_axis_tuser), .read_axis_af(read_axis_af),
    .state_out(state_out)
  );

  int checks = 0;
  int failures = 0;
  int rdy_delay = 0;
  int wdf_delay = 0;
  int rd_cmds = 0;
  int ret_model = 0;

  logic [128:0] wq[$];       // write FIFO model: {tuser, data}
  logic [29:0]  exp_cmd[$];  // {cmd, addr}
  logic [127:0] exp_wd[$];
  logic [128:0] exp_ret[$];  // {tuser, data}

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wr_if();
    write_axis_valid = (wq.size() > 0);
    if (wq.size() > 0) {write_axis_tuser, write_axis_data} = wq[0];
    else begin
      write_axis_tuser = 1'b0;
      write_axis_data  = '0;
    end
  endtask

  task automatic push_wr(input logic tuser, input logic [127:0] d);
    wq.push_back({tuser, d});
    exp_wd.push_back(d);
    drive_wr_if();
  endtask

  task automatic push_cmd(input logic [2:0] c, input int a);
    exp_cmd.push_back({c, 27'(a)});
  endtask

  // Drives one returned phrase for one cycle; called at posedge+1.
  task automatic ret_phrase(input logic [127:0] d);
    logic t;
    t = (ret_model == 0);
    exp_ret.push_back({t, d});
    ret_model = (ret_model + 1) % MAXA;
    app_rd_data = d;
    app_rd_data_valid = 1'b1;
    @(posedge clk); #1;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    @(posedge clk); #1;
  endtask

  function automatic int busy();
    return exp_cmd.size() + exp_wd.size() + exp_ret.size() + wq.size() + ((state_out != 3'd1) ? 1 : 0);
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    int pending;
    n = 0;
    pending = busy();
    while (pending != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      pending = busy();
    end
    chk(tag, 128'(pending), 128'(0));
  endtask

  // MIG model: accepts command/data after a programmable number of cycles.
  initial begin
    int en_cnt;
    int wd_cnt;
    en_cnt = 0;
    wd_cnt = 0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      en_cnt = app_en ? en_cnt + 1 : 0;
      wd_cnt = app_wdf_wren ? wd_cnt + 1 : 0;
      app_rdy = app_en && (en_cnt > rdy_delay);
      app_wdf_rdy = app_wdf_wren && (wd_cnt > wdf_delay);
    end
  end

  // Write FIFO model: next word appears after the pop.
  initial begin
    bit do_pop;
    forever begin
      @(negedge clk);
      do_pop = write_axis_ready && write_axis_valid && !rst;
      @(posedge clk); #1;
      if (do_pop && wq.size() > 0) wq.delete(0);
      drive_wr_if();
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [29:0]  ec;
    logic [128:0] er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (app_wdf_wren || app_wdf_end) chk("wdf_end_eq_wren", 128'(app_wdf_end), 128'(app_wdf_wren));
        if (app_en && app_rdy) begin
          if (app_cmd == CR) rd_cmds++;
          chk("cmd_expected", 128'(exp_cmd.size() != 0), 128'(1));
          if (exp_cmd.size() != 0) begin
            ec = exp_cmd.pop_front();
            chk("cmd_code_addr", 128'({app_cmd, app_addr}), 128'(ec));
          end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          chk("wdata_expected", 128'(exp_wd.size() != 0), 128'(1));
          chk("wdf_mask", 128'(app_wdf_mask), 128'(0));
          if (exp_wd.size() != 0) chk("wdata", app_wdf_data, exp_wd.pop_front());
        end
        if (read_axis_valid) begin
          chk("ret_expected", 128'(exp_ret.size() != 0), 128'(1));
          if (exp_ret.size() != 0) begin
            er = exp_ret.pop_front();
            chk("ret_tuser", 128'(read_axis_tuser), 128'(er[128]));
            chk("ret_data", read_axis_data, er[127:0]);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    int en_cyc;
    int wren_cyc;
    int rd_base;

    rst = 1'b1;
    calib = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    write_axis_smallpile = 1'b0;
    read_axis_af = 1'b1;
    drive_wr_if();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 128'(state_out), 128'(0));
    chk("rst_app_en", 128'(app_en), 128'(0));
    chk("rst_ready", 128'(write_axis_ready), 128'(0));
    chk("rst_wren", 128'(app_wdf_wren), 128'(0));
    chk("rst_addr", 128'(app_addr), 128'(0));
    chk("rst_rvalid", 128'(read_axis_valid), 128'(0));
    chk("rst_reqs", 128'({app_sr_req, app_ref_req, app_zq_req}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Calibration gate with a write waiting.
    rdy_delay = 3;
    wdf_delay = 0;
    push_wr(1'b1, {32{4'hA, 4'h5}});
    push_cmd(CW, 0);
    repeat (100) begin
      @(negedge clk);
      chk("calib_app_en", 128'(app_en), 128'(0));
      chk("calib_ready", 128'(write_axis_ready), 128'(0));
      chk("calib_state", 128'(state_out), 128'(0));
    end
    @(posedge clk); #1;
    calib = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2) begin
      @(negedge clk);
      n++;
      seen = write_axis_ready;
    end
    chk("calib_to_ready", 128'(seen), 128'(1));

    // First write: command stalled 3 cycles, data accepted at once.
    en_cyc = 0;
    wren_cyc = 0;
    repeat (10) begin
      @(negedge clk);
      if (app_en) begin
        en_cyc++;
        chk("wr_addr_held", 128'(app_addr), 128'(0));
        chk("wr_cmd_held", 128'(app_cmd), 128'(CW));
      end
      if (app_wdf_wren) wren_cyc++;
    end
    chk("wr_en_cycles", 128'(en_cyc), 128'(4));
    chk("wr_wren_cycles", 128'(wren_cyc), 128'(1));
    @(posedge clk); #1;
    rdy_delay = 0;
    push_wr(1'b0, 128'h1111_0000_2222_0000_3333_0000_4444_0001);
    push_cmd(CW, 8);
    drain("drain_second_write", 50);

    // Pointer wrap over a 4-phrase region; data accepted after command.
    wdf_delay = 2;
    push_wr(1'b1, 128'h10);
    push_wr(1'b0, 128'h11);
    push_wr(1'b0, 128'h12);
    push_wr(1'b0, 128'h13);
    push_wr(1'b0, 128'h14);
    push_cmd(CW, 0);
    push_cmd(CW, 8);
    push_cmd(CW, 16);
    push_cmd(CW, 24);
    push_cmd(CW, 0);
    drain("drain_wrap", 200);
    wdf_delay = 0;

    // Read throttle at two outstanding.
    rd_base = rd_cmds;
    push_cmd(CR, 0);
    push_cmd(CR, 8);
    read_axis_af = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("throttle_two_reads", 128'(rd_cmds - rd_base), 128'(2));
    push_cmd(CR, 16);
    ret_phrase(128'hDEAD_0000);
    repeat (20) @(posedge clk);
    #1;
    chk("throttle_one_more", 128'(rd_cmds - rd_base), 128'(3));
    read_axis_af = 1'b1;
    ret_phrase(128'hDEAD_0001);
    ret_phrase(128'hDEAD_0002);
    repeat (20) @(posedge clk);
    #1;
    chk("throttle_af_blocks", 128'(rd_cmds - rd_base), 128'(3));
    drain("drain_throttle", 50);

    // Alternation with smallpile=1: wr_ptr=1, rd_ptr=3, last grant was a read.
    write_axis_smallpile = 1'b1;
    push_wr(1'b0, 128'h20);
    push_wr(1'b0, 128'h21);
    push_wr(1'b0, 128'h22);
    push_wr(1'b0, 128'h23);
    push_cmd(CW, 8);
    push_cmd(CR, 24);
    push_cmd(CW, 16);
    push_cmd(CR, 0);
    push_cmd(CW, 24);   // read limit reached, remaining writes go alone
    push_cmd(CW, 0);
    read_axis_af = 1'b0;
    drain("drain_alternate", 150);
    read_axis_af = 1'b1;
    ret_phrase(128'hBEEF_0003);
    ret_phrase(128'hBEEF_0000);
    drain("drain_alt_returns", 50);

    // Urgent writes (smallpile=0) go back-to-back ahead of reads.
    write_axis_smallpile = 1'b0;
    push_wr(1'b0, 128'h30);
    push_wr(1'b0, 128'h31);
    push_wr(1'b0, 128'h32);
    push_cmd(CW, 8);
    push_cmd(CW, 16);
    push_cmd(CW, 24);
    push_cmd(CR, 8);
    push_cmd(CR, 16);
    read_axis_af = 1'b0;
    drain("drain_urgent", 150);
    read_axis_af = 1'b1;
    ret_phrase(128'hCAFE_0001);
    ret_phrase(128'hCAFE_0002);
    drain("drain_urgent_returns", 50);

    // Reset while a write command is stalled.
    rdy_delay = 100;
    push_wr(1'b1, 128'h40);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      n++;
      seen = (state_out == 3'd2);
    end
    chk("midrst_in_issue_wr", 128'(seen), 128'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    ret_model = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", 128'(state_out), 128'(0));
    chk("midrst_app_en", 128'(app_en), 128'(0));
    chk("midrst_wren", 128'(app_wdf_wren), 128'(0));
    chk("midrst_ready", 128'(write_axis_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_delay = 0;
    push_wr(1'b0, 128'h41);
    push_cmd(CW, 0);
    drain("drain_post_reset_write", 50);
    push_cmd(CR, 0);
    push_cmd(CR, 8);
    read_axis_af = 1'b0;
    drain("drain_post_reset_reads", 50);
    read_axis_af = 1'b1;
    ret_phrase(128'hF00D_0000);
    ret_phrase(128'hF00D_0001);
    drain("drain_final", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
